dlsc_cpu1_icache_ways_plru: RTL

N-way instruction-cache tag/data array with tree pseudo-LRU replacement, a self-running tag-invalidation sequencer and per-word fill tracking. It sits between the CPU1 fetch pipe, which issues reads, and the icache fill controller, which writes lines and consumes the victim select. It generalises the 1/2-way array to 1, 2, 4 or 8 ways. Tags are cleared after reset without an external init strobe.

---
 rtl/dlsc_cpu1_icache_ways_plru.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dlsc_cpu1_icache_ways_plru.sv
// dlsc_cpu1_icache_ways_plru
// N-way (1/2/4/8) instruction-cache tag/data array with tree pseudo-LRU
// replacement, a self-running tag sweep after reset, and optional per-word
// fill tracking enabled by defining DLSC_CPU1_ICACHE_CRITWORD_EN.
module dlsc_cpu1_icache_ways_plru #(
  parameter int ADDR = 30,
  parameter int DATA = 32,
  parameter int LINE = 4,
  parameter int SIZE = 9,
  parameter int WAYS = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_busy,
  input  logic [ADDR-1:0] rd_addr,
  output logic [DATA-1:0] rd_data,
  output logic            rd_miss,
  output logic [WAYS-1:0] rd_waylru,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [WAYS-1:0] wr_way,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  input  logic            wr_en_tag,
  input  logic            wr_last
);
  localparam int SETB = SIZE - LINE;
  localparam int SETS = 1 << SETB;
  localparam int TAGB = ADDR - SIZE;
  localparam int LVL  = $clog2(WAYS);
  localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1;

  generate
    if (WAYS != 1 && WAYS != 2 && WAYS != 4 && WAYS != 8) begin : g_bad_ways
      $fatal(1, "dlsc_cpu1_icache_ways_plru: WAYS must be 1, 2, 4 or 8");
    end
  endgenerate

  // Victim: walk from the root, bit=0 goes to the lower half.
  function automatic logic [WAYS-1:0] plru_victim(input logic [PW-1:0] bits);
    int node, way;
    logic d;
    logic [WAYS-1:0] oh;
    node = 0;
    way  = 0;
    for (int l = 0; l < LVL; l++) begin
      d = 1'b0;
      for (int k = 0; k < PW; k++) if (k == node) d = bits[k];
      way  = way * 2 + (d ? 1 : 0);
      node = node * 2 + 1 + (d ? 1 : 0);
    end
    oh = '0;
    for (int k = 0; k < WAYS; k++) if (k == way) oh[k] = 1'b1;
    return oh;
  endfunction

  // Touch: every node on the path of the given way points away from it.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits,
                                               input logic [WAYS-1:0] oh);
    int node, way;
    logic d;
    logic [PW-1:0] res;
    way = 0;
    for (int k = 0; k < WAYS; k++) if (oh[k]) way = k;
    res  = bits;
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      d = ((way >> (LVL - 1 - l)) & 1) != 0;
      for (int k = 0; k < PW; k++) if (k == node) res[k] = ~d;
      node = node * 2 + 1 + (d ? 1 : 0);
    end
    return res;
  endfunction

  logic            init_busy_reg;
  logic [SETB-1:0] init_set_reg;
  logic [SETB-1:0] rd_set_reg;
  logic [TAGB-1:0] rd_tag_reg;
  logic            rd_init_reg;
  logic [SETB-1:0] wr_set;
  logic [SETB-1:0] rd_set;
  logic [WAYS-1:0] way_hit;
  logic [WAYS-1:0] way_done;
  logic [DATA-1:0] way_data [WAYS];
  logic            hit_any;
  logic            hit_done;

  assign wr_set    = wr_addr[SIZE-1:LINE];
  assign rd_set    = rd_addr[SIZE-1:LINE];
  assign init_busy = init_busy_reg;

  // Tag sweep: one set per cycle starting at set 0 after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_busy_reg <= 1'b1;
      init_set_reg  <= '0;
    end else if (init_busy_reg) begin
      if (&init_set_reg) init_busy_reg <= 1'b0;
      else               init_set_reg  <= init_set_reg + 1'b1;
    end
  end

  // Read-side pipeline: remember which set/tag was looked up and whether the
  // lookup happened while the tags were still being swept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_set_reg  <= '0;
      rd_tag_reg  <= '0;
      rd_init_reg <= 1'b1;
    end else begin
      rd_set_reg  <= rd_set;
      rd_tag_reg  <= rd_addr[ADDR-1:SIZE];
      rd_init_reg <= init_busy_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAGB+1:0] tag_mem [SETS];
      logic [TAGB+1:0] tag_q;
      logic [DATA-1:0] data_mem [1 << SIZE];
      logic [DATA-1:0] data_q;

      // Tag RAM write port: sweep clears to {complete, invalid}, fill writes.
      always_ff @(posedge clk) begin
        if (init_busy_reg)
          tag_mem[init_set_reg] <= {1'b1, 1'b0, {TAGB{1'b0}}};
        else if (wr_en_tag && wr_way[gi])
          tag_mem[wr_set] <= {wr_last, wr_en, wr_addr[ADDR-1:SIZE]};
      end

      // Data RAM write port; fills are ignored while sweeping.
      always_ff @(posedge clk) begin
        if (!init_busy_reg && wr_en && wr_way[gi])
          data_mem[wr_addr[SIZE-1:0]] <= wr_data;
      end

      // Registered reads of both RAMs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tag_q  <= '0;
          data_q <= '0;
        end else begin
          tag_q  <= tag_mem[rd_set];
          data_q <= data_mem[rd_addr[SIZE-1:0]];
        end
      end

      assign way_hit[gi]  = tag_q[TAGB] && (tag_q[TAGB-1:0] == rd_tag_reg);
      assign way_done[gi] = tag_q[TAGB+1];
      assign way_data[gi] = data_q;
    end
  endgenerate

  assign hit_any  = |way_hit;
  assign hit_done = |(way_hit & way_done);

  // Output mux: OR of the hitting way (zero when nothing hits).
  always_comb begin
    rd_data = '0;
    for (int w = 0; w < WAYS; w++) if (way_hit[w]) rd_data = rd_data | way_data[w];
  end

`ifdef DLSC_CPU1_ICACHE_CRITWORD_EN
  localparam int WORDS = 1 << LINE;
  logic [WORDS-1:0] status_reg;
  logic             flag_reg;
  logic             rd_status_reg;
  logic             rd_flag_reg;

  // Fill status: words written stamp the current flag, line completion flips
  // the flag so every stamp of the finished line goes stale at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg <= '1;
      flag_reg   <= 1'b0;
    end else if (init_busy_reg) begin
      status_reg <= '1;
      flag_reg   <= 1'b0;
    end else begin
      if (wr_en)               status_reg[wr_addr[LINE-1:0]] <= flag_reg;
      if (wr_en_tag && wr_last) flag_reg <= ~flag_reg;
    end
  end

  // Capture the word status and the flag alongside the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_status_reg <= 1'b1;
      rd_flag_reg   <= 1'b0;
    end else begin
      rd_status_reg <= status_reg[rd_addr[LINE-1:0]];
      rd_flag_reg   <= flag_reg;
    end
  end

  assign rd_miss = rd_init_reg || !(hit_any && (hit_done || (rd_status_reg == rd_flag_reg)));
`else
  assign rd_miss = rd_init_reg || !hit_done;
`endif

  generate
    if (WAYS == 1) begin : g_plru_none
      assign rd_waylru = 1'b1;
    end else begin : g_plru
      logic [PW-1:0] plru_mem [SETS];
      logic          fill_upd;
      logic          hit_upd;

      assign fill_upd = wr_en_tag && wr_last;
      assign hit_upd  = !rd_init_reg && hit_any;

      // PLRU write: sweep clears, a fill completion beats a read hit.
      always_ff @(posedge clk) begin
        if (init_busy_reg)
          plru_mem[init_set_reg] <= '0;
        else if (fill_upd)
          plru_mem[wr_set] <= plru_touch(plru_mem[wr_set], wr_way);
        else if (hit_upd)
          plru_mem[rd_set_reg] <= plru_touch(plru_mem[rd_set_reg], way_hit);
      end

      assign rd_waylru = rd_init_reg ? WAYS'(1) : plru_victim(plru_mem[rd_set_reg]);
    end
  endgenerate

endmodule
